temp_sample_controller: RTL and testbench

//  Sequences the smart-home temperature path: ADC capture, TemperatureCalculator, averaging, heater/cooler.
//  - Periodically requests an ADC sample over a req/ack handshake.
//  - Holds the sample on calc_adc for the TemperatureCalculator and captures its tempc result.
//  - Averages 2^AVG_SHIFT results and drives heater/cooler enables with hysteresis around set_point.
//  - Sits at SmartHome top level, beside the TemperatureCalculator instance.

---
 rtl/smart_home_pkg.sv | 54 +++++
 rtl/sample_period_timer.sv | 48 ++++
 rtl/temp_sample_controller.sv | 199 +++++++++++++++++++
 tb/tb_temp_sample_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/smart_home_pkg.sv
// Shared widths, FSM encodings and the hysteresis decision for the temperature path.
package smart_home_pkg;

   localparam int ADC_W  = 16;
   localparam int TEMP_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_TICK = 3'd1,
      ST_REQ       = 3'd2,
      ST_SETTLE    = 3'd3,
      ST_UPDATE    = 3'd4
   } state_e;

   // Returns {heater, cooler} for a new average. Math is done two bits wider so
   // set_point +/- hyst can never wrap. Inside the band an output only turns off
   // once the average has crossed the set point; otherwise it holds.
   function automatic logic [1:0] hyst_next(input logic signed [TEMP_W-1:0] avg,
                                            input logic signed [TEMP_W-1:0] sp,
                                            input int                       hyst,
                                            input logic                     heater,
                                            input logic                     cooler);
      logic signed [TEMP_W+1:0] a;
      logic signed [TEMP_W+1:0] s;
      logic signed [TEMP_W+1:0] lo;
      logic signed [TEMP_W+1:0] hi;
      logic                     h;
      logic                     c;
      a  = {{2{avg[TEMP_W-1]}}, avg};
      s  = {{2{sp[TEMP_W-1]}}, sp};
      lo = s - (TEMP_W+2)'(hyst);
      hi = s + (TEMP_W+2)'(hyst);
      if (a < lo) begin
         h = 1'b1;
         c = 1'b0;
      end else if (a > hi) begin
         h = 1'b0;
         c = 1'b1;
      end else begin
         if (a >= s) begin
            h = 1'b0;
         end else begin
            h = heater;
         end
         if (a <= s) begin
            c = 1'b0;
         end else begin
            c = cooler;
         end
      end
      return {h, c};
   endfunction

endpackage

// File: rtl/sample_period_timer.sv
// Free-running sample period counter; emits a registered one-cycle tick on wrap.
// Held at zero while enable is low so a fresh enable starts a full period.
module sample_period_timer #(
   parameter int SAMPLE_PERIOD = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable_i,
   output logic tick_o
);

   localparam int CNT_W = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             tick_q;
   logic             tick_d;

   // Next-state for the period counter and its wrap tick.
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (!enable_i) begin
         cnt_d  = {CNT_W{1'b0}};
         tick_d = 1'b0;
      end else if (cnt_q == CNT_W'(SAMPLE_PERIOD - 1)) begin
         cnt_d  = {CNT_W{1'b0}};
         tick_d = 1'b1;
      end else begin
         cnt_d  = cnt_q + CNT_W'(1);
         tick_d = 1'b0;
      end
   end

   // Counter and tick registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= {CNT_W{1'b0}};
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/temp_sample_controller.sv
// Temperature path sequencer: periodic ADC request/ack, hands the sample to the
// external TemperatureCalculator, averages 2^AVG_SHIFT results and drives the
// heater/cooler enables with hysteresis around the set point.
module temp_sample_controller
   import smart_home_pkg::*;
#(
   parameter int SAMPLE_PERIOD = 1000,
   parameter int ADC_TIMEOUT   = 64,
   parameter int AVG_SHIFT     = 2,
   parameter int HYST          = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable_i,
   input  logic [TEMP_W-1:0] set_point_i,
   output logic              adc_req_o,
   input  logic              adc_ack_i,
   input  logic [ADC_W-1:0]  adc_data_in_i,
   output logic [ADC_W-1:0]  calc_adc_o,
   input  logic [TEMP_W-1:0] calc_tempc_i,
   output logic [TEMP_W-1:0] temp_out_o,
   output logic              temp_valid_o,
   output logic              heater_on_o,
   output logic              cooler_on_o,
   output logic              adc_timeout_o
);

   localparam int ACC_W   = TEMP_W + AVG_SHIFT;
   localparam int CNT_W   = AVG_SHIFT + 1;
   localparam int WAIT_W  = $clog2(ADC_TIMEOUT + 1);
   localparam int SAMPLES = 1 << AVG_SHIFT;

   state_e                   state_q,   state_d;
   logic                     pend_q,    pend_d;
   logic [WAIT_W-1:0]        wait_q,    wait_d;
   logic signed [ACC_W-1:0]  acc_q,     acc_d;
   logic [CNT_W-1:0]         cnt_q,     cnt_d;
   logic                     req_q,     req_d;
   logic [ADC_W-1:0]         cadc_q,    cadc_d;
   logic [TEMP_W-1:0]        tout_q,    tout_d;
   logic                     tvalid_q,  tvalid_d;
   logic                     heater_q,  heater_d;
   logic                     cooler_q,  cooler_d;
   logic                     tmo_q,     tmo_d;

   logic                     tick_s;
   logic                     take_s;
   logic signed [ACC_W-1:0]  acc_shift_s;
   logic signed [TEMP_W-1:0] avg_s;
   logic signed [ACC_W-1:0]  tempc_ext_s;
   logic [1:0]               hyst_s;

   sample_period_timer #(
      .SAMPLE_PERIOD (SAMPLE_PERIOD)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable_i (enable_i),
      .tick_o   (tick_s)
   );

   // Average (floor via arithmetic shift), sign-extended sample and hysteresis decision.
   always_comb begin
      acc_shift_s = acc_q >>> AVG_SHIFT;
      avg_s       = acc_shift_s[TEMP_W-1:0];
      tempc_ext_s = {{AVG_SHIFT{calc_tempc_i[TEMP_W-1]}}, calc_tempc_i};
      hyst_s      = hyst_next(avg_s, $signed(set_point_i), HYST, heater_q, cooler_q);
   end

   // FSM next-state and registered-output next values.
   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      wait_d   = wait_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      req_d    = req_q;
      cadc_d   = cadc_q;
      tout_d   = tout_q;
      tvalid_d = 1'b0;
      heater_d = heater_q;
      cooler_d = cooler_q;
      tmo_d    = tmo_q;
      take_s   = 1'b0;
      if (!enable_i) begin
         // Abort from any state; temp_out and calc_adc keep their last values.
         state_d  = ST_IDLE;
         pend_d   = 1'b0;
         wait_d   = {WAIT_W{1'b0}};
         acc_d    = {ACC_W{1'b0}};
         cnt_d    = {CNT_W{1'b0}};
         req_d    = 1'b0;
         heater_d = 1'b0;
         cooler_d = 1'b0;
         tmo_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_WAIT_TICK;
            end
            ST_WAIT_TICK: begin
               if (pend_q) begin
                  take_s  = 1'b1;
                  req_d   = 1'b1;
                  wait_d  = {WAIT_W{1'b0}};
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_WAIT_TICK;
               end
            end
            ST_REQ: begin
               if (adc_ack_i) begin
                  cadc_d  = adc_data_in_i;
                  req_d   = 1'b0;
                  state_d = ST_SETTLE;
               end else if (wait_q == WAIT_W'(ADC_TIMEOUT - 1)) begin
                  // Give up on this sample and restart the average from scratch.
                  req_d   = 1'b0;
                  tmo_d   = 1'b1;
                  acc_d   = {ACC_W{1'b0}};
                  cnt_d   = {CNT_W{1'b0}};
                  state_d = ST_WAIT_TICK;
               end else begin
                  wait_d  = wait_q + WAIT_W'(1);
               end
            end
            ST_SETTLE: begin
               acc_d = acc_q + tempc_ext_s;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(SAMPLES - 1)) begin
                  state_d = ST_UPDATE;
               end else begin
                  state_d = ST_WAIT_TICK;
               end
            end
            ST_UPDATE: begin
               tout_d   = avg_s;
               tvalid_d = 1'b1;
               heater_d = hyst_s[1];
               cooler_d = hyst_s[0];
               acc_d    = {ACC_W{1'b0}};
               cnt_d    = {CNT_W{1'b0}};
               state_d  = ST_WAIT_TICK;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
         // One-deep tick buffer: a tick landing while one is pending is lost.
         if (tick_s) begin
            pend_d = 1'b1;
         end else if (take_s) begin
            pend_d = 1'b0;
         end else begin
            pend_d = pend_q;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         pend_q   <= 1'b0;
         wait_q   <= {WAIT_W{1'b0}};
         acc_q    <= {ACC_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
         req_q    <= 1'b0;
         cadc_q   <= {ADC_W{1'b0}};
         tout_q   <= {TEMP_W{1'b0}};
         tvalid_q <= 1'b0;
         heater_q <= 1'b0;
         cooler_q <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         wait_q   <= wait_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         req_q    <= req_d;
         cadc_q   <= cadc_d;
         tout_q   <= tout_d;
         tvalid_q <= tvalid_d;
         heater_q <= heater_d;
         cooler_q <= cooler_d;
         tmo_q    <= tmo_d;
      end
   end

   assign adc_req_o     = req_q;
   assign calc_adc_o    = cadc_q;
   assign temp_out_o    = tout_q;
   assign temp_valid_o  = tvalid_q;
   assign heater_on_o   = heater_q;
   assign cooler_on_o   = cooler_q;
   assign adc_timeout_o = tmo_q;

endmodule

// File: tb/tb_temp_sample_controller.sv
// Directed bench for temp_sample_controller with a scoreboard of expected averages.
module tb_temp_sample_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable_i;
   logic [31:0] set_point_i;
   logic        adc_req_o;
   logic        adc_ack_i;
   logic [15:0] adc_data_in_i;
   logic [15:0] calc_adc_o;
   logic [31:0] calc_tempc_i;
   logic [31:0] temp_out_o;
   logic        temp_valid_o;
   logic        heater_on_o;
   logic        cooler_on_o;
   logic        adc_timeout_o;

   typedef struct {
      logic [31:0] t;
      logic        h;
      logic        c;
   } exp_t;

   exp_t  exp_q[$];
   exp_t  mon_e;
   int    checks    = 0;
   int    errors    = 0;
   int    valid_cnt = 0;
   int    vc;
   int    n;
   logic  seen;
   logic [15:0] data_ctr = 16'h8001;

   temp_sample_controller #(
      .SAMPLE_PERIOD (16),
      .ADC_TIMEOUT   (8),
      .AVG_SHIFT     (2),
      .HYST          (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable_i      (enable_i),
      .set_point_i   (set_point_i),
      .adc_req_o     (adc_req_o),
      .adc_ack_i     (adc_ack_i),
      .adc_data_in_i (adc_data_in_i),
      .calc_adc_o    (calc_adc_o),
      .calc_tempc_i  (calc_tempc_i),
      .temp_out_o    (temp_out_o),
      .temp_valid_o  (temp_valid_o),
      .heater_on_o   (heater_on_o),
      .cooler_on_o   (cooler_on_o),
      .adc_timeout_o (adc_timeout_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for a request, acks it with value v for the calculator.
   task automatic do_sample(input int v);
      int k;
      k = 0;
      while (!adc_req_o && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk("req_seen", {31'd0, adc_req_o}, 32'd1);
      data_ctr      = data_ctr + 16'd3;
      adc_ack_i     = 1'b1;
      adc_data_in_i = data_ctr;
      calc_tempc_i  = v;
      @(negedge clk);
      adc_ack_i = 1'b0;
      chk("calc_adc", {16'd0, calc_adc_o}, {16'd0, data_ctr});
      chk("req_drop", {31'd0, adc_req_o}, 32'd0);
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk("valid_arrive", exp_q.size(), 32'd0);
   endtask

   task automatic do_group(input int a, input int b, input int c, input int d,
                           input int et, input logic eh, input logic ec);
      exp_t e;
      e.t = et;
      e.h = eh;
      e.c = ec;
      exp_q.push_back(e);
      do_sample(a);
      do_sample(b);
      do_sample(c);
      do_sample(d);
      wait_drain();
   endtask

   // Monitor: every temp_valid pulse must match the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && temp_valid_o === 1'b1) begin
            valid_cnt++;
            chk("valid_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               chk("temp_out", temp_out_o, mon_e.t);
               chk("heater", {31'd0, heater_on_o}, {31'd0, mon_e.h});
               chk("cooler", {31'd0, cooler_on_o}, {31'd0, mon_e.c});
            end
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      enable_i      = 1'b0;
      set_point_i   = 32'd30;
      adc_ack_i     = 1'b0;
      adc_data_in_i = 16'd0;
      calc_tempc_i  = 32'd0;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_flags", {27'd0, adc_req_o, temp_valid_o, heater_on_o, cooler_on_o, adc_timeout_o}, 32'd0);
      chk("rst_temp_out", temp_out_o, 32'd0);
      chk("rst_calc_adc", {16'd0, calc_adc_o}, 32'd0);

      // Released with enable low: nothing happens.
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         seen = seen | adc_req_o;
      end
      chk("idle_req_never", {31'd0, seen}, 32'd0);
      chk("idle_flags", {27'd0, adc_req_o, temp_valid_o, heater_on_o, cooler_on_o, adc_timeout_o}, 32'd0);

      // Basic average: 103/4 floors to 25, below band -> heater.
      enable_i = 1'b1;
      do_group(25, 25, 26, 27, 25, 1'b1, 1'b0);
      chk("one_pulse_g1", valid_cnt, 32'd1);

      // Hysteresis walk around set point 30.
      do_group(29, 29, 29, 29, 29, 1'b1, 1'b0);
      do_group(30, 30, 30, 30, 30, 1'b0, 1'b0);
      do_group(33, 33, 33, 33, 33, 1'b0, 1'b1);
      do_group(30, 30, 30, 30, 30, 1'b0, 1'b0);

      // Negative average floors: -33/4 -> -9.
      do_group(-8, -8, -8, -9, -9, 1'b1, 1'b0);
      chk("pulse_count_g6", valid_cnt, 32'd6);

      // ADC timeout: request held 8 cycles then dropped, sticky flag, no update.
      vc = valid_cnt;
      n  = 0;
      while (!adc_req_o && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_req_rise", {31'd0, adc_req_o}, 32'd1);
      n = 0;
      while (adc_req_o && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("tmo_req_width", n, 32'd8);
      chk("tmo_flag", {31'd0, adc_timeout_o}, 32'd1);
      n = 0;
      while (!adc_req_o && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_rerequest", {31'd0, adc_req_o}, 32'd1);
      chk("tmo_no_valid", valid_cnt, vc);
      do_group(20, 20, 20, 20, 20, 1'b1, 1'b0);
      chk("tmo_sticky", {31'd0, adc_timeout_o}, 32'd1);

      // Enable dropped mid-handshake.
      n = 0;
      while (!adc_req_o && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("abort_req_rise", {31'd0, adc_req_o}, 32'd1);
      enable_i = 1'b0;
      @(negedge clk);
      chk("abort_flags", {28'd0, adc_req_o, heater_on_o, cooler_on_o, adc_timeout_o}, 32'd0);
      chk("abort_temp_hold", temp_out_o, 32'd20);
      repeat (5) @(negedge clk);
      chk("abort_idle_req", {31'd0, adc_req_o}, 32'd0);

      // Re-enable: no update until four fresh samples.
      enable_i = 1'b1;
      vc       = valid_cnt;
      do_sample(40);
      do_sample(40);
      do_sample(40);
      repeat (6) @(negedge clk);
      chk("reenable_no_early_valid", valid_cnt, vc);
      begin
         exp_t e;
         e.t = 32'd40;
         e.h = 1'b0;
         e.c = 1'b1;
         exp_q.push_back(e);
      end
      do_sample(41);
      wait_drain();
      chk("reenable_one_pulse", valid_cnt, vc + 1);

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
